// File: rtl/fifo_psram_pkg.sv
// Shared defaults and types for the pSRAM IO write-data buffer.
package fifo_psram_pkg;

  localparam int DEF_DATA_W    = 18;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_BURST_LEN = 8;

  // Pointers carry one extra wrap bit above the memory address.
  typedef logic [DEF_ADDR_W:0] ptr_t;
  typedef logic [DEF_ADDR_W:0] level_t;

endpackage

// File: rtl/fifo_psram_io_wr_mem.sv
// Simple dual-port storage with a registered read port (EMB5K sdp-mode shape).
module fifo_psram_io_wr_mem
  import fifo_psram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] aw,
  input  logic [DATA_W-1:0] dw,
  input  logic              ce,
  input  logic [ADDR_W-1:0] ar,
  output logic [DATA_W-1:0] qr
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] qr_q;
  logic [DATA_W-1:0] qr_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[aw] <= dw;
    end
  end

  // The output register holds its value between reads; only it is reset.
  always_comb begin
    qr_d = qr_q;
    if (ce) begin
      qr_d = mem[ar];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      qr_q <= '0;
    end else begin
      qr_q <= qr_d;
    end
  end

  assign qr = qr_q;

endmodule

// File: rtl/fifo_psram_io_wr_buf.sv
// Write-data buffer for the pSRAM IO path: pushes from user logic, burst pops by the controller.
// Define FIFO_PSRAM_WR_ERR_EN to add sticky ovf_err/unf_err outputs.
module fifo_psram_io_wr_buf
  import fifo_psram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              burst_rdy
`ifdef FIFO_PSRAM_WR_ERR_EN
  ,
  output logic              ovf_err,
  output logic              unf_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] BURST_L = (ADDR_W+1)'(BURST_LEN);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            burst_q, burst_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push, pop;

  // Handshake: a push is taken when wr_en=1 and registered full=0, a pop when
  // rd_en=1 and registered empty=0; popped data appears with rd_valid one cycle later.
  // Flush blocks both in its cycle.
  assign push = wr_en & ~full_q  & ~flush;
  assign pop  = rd_en & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = pop;
    ovf_d      = ovf_q | (wr_en & full_q);
    unf_d      = unf_q | (rd_en & empty_q);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == DEPTH_L);
    burst_d = (level_d >= BURST_L);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      burst_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      burst_q    <= burst_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  fifo_psram_io_wr_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk (clk),
    .rstn(rstn),
    .we  (push),
    .aw  (wr_ptr_q[ADDR_W-1:0]),
    .dw  (wr_data),
    .ce  (pop),
    .ar  (rd_ptr_q[ADDR_W-1:0]),
    .qr  (rd_data)
  );

  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign burst_rdy = burst_q;
  assign rd_valid  = rd_valid_q;

`ifdef FIFO_PSRAM_WR_ERR_EN
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`else
  logic unused_err;
  assign unused_err = ovf_q ^ unf_q;
`endif

endmodule

// File: tb/tb_fifo_psram_io_wr_buf.sv
// Scoreboard bench for fifo_psram_io_wr_buf against a queue-based reference model.
module tb_fifo_psram_io_wr_buf;

  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BL    = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   level;
  logic          burst_rdy;
`ifdef FIFO_PSRAM_WR_ERR_EN
  logic          ovf_err;
  logic          unf_err;
`endif

  fifo_psram_io_wr_buf dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .level    (level),
    .burst_rdy(burst_rdy)
`ifdef FIFO_PSRAM_WR_ERR_EN
    ,
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
`endif
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Reference model and scoreboard
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          mon_en = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one clock cycle of stimulus; the model applies the same rules the
  // buffer promises (capacity DEPTH, FIFO order, flush/reset discard).
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
    bit was_full, was_empty;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (!rstn) begin
      m_q.delete();
      exp_q.delete();
      exp_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      m_q.delete();
      exp_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (we && was_full) m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
      exp_valid = re && !was_empty;
      if (exp_valid) exp_q.push_back(m_q.pop_front());
      if (we && !was_full) m_q.push_back(wd);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] wd);
    step(1'b1, wd, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    while (m_q.size() > 0) pop();
    idle();
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  // Monitor: compares DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
      chk("level", 32'(level), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("burst_rdy", 32'(burst_rdy), 32'(m_q.size() >= BL));
`ifdef FIFO_PSRAM_WR_ERR_EN
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      chk("unf_err", 32'(unf_err), 32'(m_unf));
`endif
    end
  end

  initial begin
    // Reset
    rstn = 1'b0;
    repeat (3) idle();
    mon_en = 1'b1;
    chk("rd_data_reset", 32'(rd_data), 32'd0);
    rstn = 1'b1;
    idle();

    // Basic order
    for (int i = 1; i <= 5; i++) push(DW'(i));
    for (int i = 0; i < 5; i++) pop();
    idle();

    // Full boundary: 17th push dropped
    for (int i = 0; i < 17; i++) push(rnd());
    drain();

    // Burst threshold
    for (int i = 0; i < 7; i++) push(rnd());
    push(rnd());
    pop();
    drain();

    // Simultaneous push+pop: full, empty, mid-level
    for (int i = 0; i < DEPTH; i++) push(rnd());
    step(1'b1, rnd(), 1'b1, 1'b0);
    drain();
    step(1'b1, rnd(), 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) push(rnd());
    step(1'b1, rnd(), 1'b1, 1'b0);
    drain();

    // Randomized traffic with level kept in 1..15 across many wraps
    for (int i = 0; i < 8; i++) push(rnd());
    for (int i = 0; i < 100; i++) begin
      logic we, re;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if (m_q.size() >= DEPTH - 1) we = 1'b0;
      if (m_q.size() <= 1) re = 1'b0;
      step(we, rnd(), re, 1'b0);
    end
    drain();

    // Flush alongside a write at level 10
    for (int i = 0; i < 10; i++) push(rnd());
    step(1'b1, rnd(), 1'b0, 1'b1);
    idle();

    // Error flags: underflow and overflow are sticky until flush
    pop();
    idle();
    idle();
    for (int i = 0; i < DEPTH + 1; i++) push(rnd());
    idle();
    step(1'b0, '0, 1'b0, 1'b1);
    idle();

    // Reset mid-burst discards data and drops rd_valid
    for (int i = 0; i < 6; i++) push(rnd());
    pop();
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    idle();
    push(DW'(18'h2a5a5));
    pop();
    idle();

    mon_en = 1'b0;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
